stream_serializer: RTL and testbench

- Valid/ready width down-converter. Accepts one wide word of RATIO×DATA_WIDTH bits upstream and emits RATIO narrow beats downstream, least-significant slice first.
- Marks the final beat of each word with o_last.
- Sits between wide internal datapaths and narrow egress interfaces, using the same handshake semantics as the library's FIFOs.
- Full throughput: a new word is accepted in the same cycle its predecessor's last beat transmits.

---
 rtl/stream_serializer.sv | 75 +++++++
 tb/tb_stream_serializer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_serializer.sv
// Valid/ready width down-converter: one RATIO*DATA_WIDTH word in, RATIO narrow beats out,
// least-significant slice first, with o_last flagging the final beat of each word.
module stream_serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RATIO      = 4
) (
  input  logic                        i_clock,
  input  logic                        i_aresetn,
  input  logic [DATA_WIDTH*RATIO-1:0] i_data,
  input  logic                        i_input_valid,
  output logic                        o_input_ready,
  output logic [DATA_WIDTH-1:0]       o_data,
  output logic                        o_output_valid,
  output logic                        o_last,
  input  logic                        i_output_ready
);

  localparam int unsigned WordW = DATA_WIDTH * RATIO;
  localparam int unsigned BeatW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(RATIO - 1);

  initial begin
    if (DATA_WIDTH < 1) $fatal(1, "stream_serializer: DATA_WIDTH must be >= 1");
    if (RATIO < 1)      $fatal(1, "stream_serializer: RATIO must be >= 1");
  end

  logic [WordW-1:0] sreg_q, sreg_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic             valid_q, valid_d;
  logic             last;
  logic             accept;
  logic             transmit;

  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      sreg_q  <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
    end
  end

  // Ready is combinational from downstream ready so a new word can land on the last beat.
  always_comb begin
    last           = valid_q && (beat_q == LastBeat);
    o_last         = last;
    o_output_valid = valid_q;
    o_data         = sreg_q[DATA_WIDTH-1:0];
    o_input_ready  = i_aresetn && (!valid_q || (last && i_output_ready));
    accept         = i_input_valid && o_input_ready;
    transmit       = valid_q && i_output_ready;
  end

  always_comb begin
    sreg_d  = sreg_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    if (accept) begin
      sreg_d  = i_data;
      beat_d  = '0;
      valid_d = 1'b1;
    end else if (transmit && !last) begin
      sreg_d = sreg_q >> DATA_WIDTH;
      beat_d = beat_q + BeatW'(1);
    end else if (transmit) begin
      // sreg is left as-is; o_data is don't-care while valid is low.
      valid_d = 1'b0;
      beat_d  = '0;
    end
  end

endmodule

// File: tb/tb_stream_serializer.sv
// Scoreboard bench for stream_serializer: a RATIO=4 instance and a RATIO=1 instance.
module tb_stream_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [31:0] idata = '0;
  logic        iv = 1'b0, ordy = 1'b1;
  logic        in_rdy, out_vld, out_last;
  logic [7:0]  out_data;

  logic [7:0]  idata1 = '0;
  logic        iv1 = 1'b0, ordy1 = 1'b1;
  logic        in_rdy1, out_vld1, out_last1;
  logic [7:0]  out_data1;

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] sb_q[$];
  logic [8:0] sb1_q[$];
  logic acc, acc1;
  int beats1 = 0;

  always #5 clk = ~clk;

  stream_serializer #(.DATA_WIDTH(8), .RATIO(4)) dut (
    .i_clock        (clk),
    .i_aresetn      (rst_n),
    .i_data         (idata),
    .i_input_valid  (iv),
    .o_input_ready  (in_rdy),
    .o_data         (out_data),
    .o_output_valid (out_vld),
    .o_last         (out_last),
    .i_output_ready (ordy)
  );

  stream_serializer #(.DATA_WIDTH(8), .RATIO(1)) dut1 (
    .i_clock        (clk),
    .i_aresetn      (rst_n),
    .i_data         (idata1),
    .i_input_valid  (iv1),
    .o_input_ready  (in_rdy1),
    .o_data         (out_data1),
    .o_output_valid (out_vld1),
    .o_last         (out_last1),
    .i_output_ready (ordy1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs are set right after a negedge; observe at +1, then wait for the next negedge.
  task automatic tick();
    logic [8:0] e;
    #1;
    acc  = iv && in_rdy;
    acc1 = iv1 && in_rdy1;
    if (out_vld && ordy) begin
      check_eq("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_eq("beat", {23'd0, out_last, out_data}, {23'd0, e});
      end
    end
    if (out_vld1 && ordy1) begin
      beats1++;
      check_eq("r1_sb_nonempty", 32'(sb1_q.size() > 0), 32'd1);
      if (sb1_q.size() > 0) begin
        e = sb1_q.pop_front();
        check_eq("r1_beat", {23'd0, out_last1, out_data1}, {23'd0, e});
      end
    end
    if (acc) for (int k = 0; k < 4; k++) sb_q.push_back({k == 3, idata[8*k +: 8]});
    if (acc1) sb1_q.push_back({1'b1, idata1});
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    iv = 1'b0;
    ordy = 1'b1;
    while (sb_q.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] single_exp[4];
    logic [7:0] r1_vals[3];
    int idx;
    int n;
    single_exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    r1_vals    = '{8'h11, 8'h22, 8'h33};

    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset asserted mid-run, no input.
    rst_n = 1'b0;
    #1;
    check_eq("rst_valid", 32'(out_vld), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_last", 32'(out_last), 32'd0);
    check_eq("rst_ready", 32'(in_rdy), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("idle_ready", 32'(in_rdy), 32'd1);
    check_eq("idle_valid", 32'(out_vld), 32'd0);
    tick();

    // Single word with ready high.
    iv = 1'b1; idata = 32'hDDCCBBAA; ordy = 1'b1;
    tick();
    iv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("single_valid", 32'(out_vld), 32'd1);
      check_eq("single_data", 32'(out_data), 32'(single_exp[k]));
      check_eq("single_last", 32'(out_last), 32'(k == 3));
      check_eq("single_ready", 32'(in_rdy), 32'(k == 3));
      tick();
    end
    #1;
    check_eq("single_done_valid", 32'(out_vld), 32'd0);
    tick();

    // Back-to-back words, no bubble; second accepted on beat 0x03.
    iv = 1'b1; idata = 32'h03020100;
    tick();
    idata = 32'h07060504;
    for (int c = 0; c < 8; c++) begin
      #1;
      check_eq("b2b_valid", 32'(out_vld), 32'd1);
      check_eq("b2b_data", 32'(out_data), 32'(c));
      tick();
      if (acc) begin
        check_eq("b2b_accept_beat", 32'(c), 32'd3);
        iv = 1'b0;
      end
    end
    drain("b2b");

    // Downstream stall while 0xBB is presented; a held input must not be accepted.
    iv = 1'b1; idata = 32'hDDCCBBAA;
    tick();
    iv = 1'b0;
    tick();
    ordy = 1'b0; iv = 1'b1; idata = 32'h55555555;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq("stall_data", 32'(out_data), 32'hBB);
      check_eq("stall_valid", 32'(out_vld), 32'd1);
      check_eq("stall_ready", 32'(in_rdy), 32'd0);
      tick();
      check_eq("stall_no_accept", 32'(acc), 32'd0);
    end
    iv = 1'b0; ordy = 1'b1;
    tick();
    #1;
    check_eq("stall_resume", 32'(out_data), 32'hCC);
    drain("stall");

    // Reset mid-word after 0xBB; the rest of the word is discarded.
    iv = 1'b1; idata = 32'hDDCCBBAA;
    tick();
    iv = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(out_vld), 32'd0);
    check_eq("midrst_data", 32'(out_data), 32'd0);
    sb_q.delete();
    sb1_q.delete();
    tick();
    rst_n = 1'b1;
    iv = 1'b1; idata = 32'h44332211;
    tick();
    check_eq("midrst_accept", 32'(acc), 32'd1);
    iv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("midrst_data_seq", 32'(out_data), 32'(8'h11 * (k + 1)));
      tick();
    end
    #1;
    check_eq("midrst_done", 32'(out_vld), 32'd0);
    tick();

    // RATIO=1 instance with random downstream ready.
    idx = 0; n = 0; beats1 = 0;
    while ((idx < 3 || sb1_q.size() > 0) && n < 200) begin
      iv1    = (idx < 3);
      idata1 = (idx < 3) ? r1_vals[idx] : 8'h00;
      ordy1  = 1'($urandom_range(0, 1));
      tick();
      if (acc1) idx++;
      n++;
    end
    iv1 = 1'b0; ordy1 = 1'b1;
    check_eq("r1_all_accepted", 32'(idx), 32'd3);
    check_eq("r1_beat_count", 32'(beats1), 32'd3);
    check_eq("r1_drained", 32'(sb1_q.size()), 32'd0);
    tick();
    #1;
    check_eq("r1_idle", 32'(out_vld1), 32'd0);

    check_eq("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
